vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Shares the single `vga_adapter` plot port between several tile drawers: apple painter, snake-body painter and eraser. Each requester asks for one TILE×TILE square at a given (x,y) in a given colour. The arbiter grants one requester at a time and walks the pixel counters itself. It drives `VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot`, then signals completion. This replaces per-FSM XC/YC counters and the output mux in the game top level.

## Interface
- `NREQ`, 3, number of requesters (2..8)
- `TILE`, 10, square edge in pixels (1..16)
- `XSCREEN`, 160, visible width; pixels at x ≥ XSCREEN are not plotted
- `YSCREEN`, 120, visible height; pixels at y ≥ YSCREEN are not plotted

- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester draw request, level, held until `done`
- `req_x`  in  8·NREQ  packed tile origin x, requester i at [8i+7:8i]
- `req_y`  in  7·NREQ  packed tile origin y, requester i at [7i+6:7i]
- `req_colour`  in  3·NREQ  packed colour, requester i at [3i+2:3i]
- `grant`  out  NREQ  one-hot owner of the plot port, zero when idle
- `done`  out  NREQ  one-cycle pulse to the owner when its tile is finished
- `busy`  out  1  high in FILL and DONE
- `VGA_X`  out  8  pixel x to `vga_adapter`
- `VGA_Y`  out  7  pixel y to `vga_adapter`
- `VGA_COLOR`  out  3  pixel colour to `vga_adapter`
- `plot`  out  1  pixel write strobe to `vga_adapter`

## Operation
- States: IDLE, FILL, DONE.
- **IDLE**
  - If `req` ≠ 0, select winner g by the arbitration rule.
  - Latch `req_x[g]`, `req_y[g]`, `req_colour[g]` into x0, y0 and col.
  - Clear xc and yc, set grant = 1<<g, go to FILL.
  - Otherwise stay in IDLE.
- **FILL**
  - `VGA_X` = x0+xc (8-bit, modulo 256). `VGA_Y` = y0+yc (7-bit, modulo 128). `VGA_COLOR` = col.
  - `plot` = 1 unless the unwrapped sum x0+xc ≥ XSCREEN or y0+yc ≥ YSCREEN. Compute the compare at 9 bits so no wrap occurs.
  - xc increments each cycle. At xc = TILE-1, xc returns to 0 and yc increments.
  - At (xc,yc) = (TILE-1,TILE-1), go to DONE.
- **DONE**
  - `done[g]` = 1 for one cycle; `plot` = 0.
  - Update the arbitration pointer.
  - Clear grant, go to IDLE.
- Latched origin and colour are immune to input changes during FILL.
- Dropping `req[g]` mid-FILL does not abort; the tile completes and `done[g]` still pulses.
- Requests arriving while busy wait; none are lost while held.
- Requester's side: after `done`, drop `req` for at least one cycle or it re-enters arbitration with its current coordinates.
- Default arbitration (round robin)
  - Pointer p, reset 0.
  - The winner is the first requesting index scanning p, p+1, … modulo NREQ.
  - In DONE, p ← g+1 modulo NREQ.

## Timing
- Reset values: grant = 0, done = 0, busy = 0, plot = 0, VGA_X = 0, VGA_Y = 0, VGA_COLOR = 0, state IDLE, xc = yc = 0, p = 0.
- All outputs are combinational from registered state only; no input-to-output path.
- Latency and throughput
  - `req` sampled high at edge k gives grant and the first pixel in cycle k+1.
  - FILL lasts exactly TILE² cycles.
  - DONE is one cycle, so a tile occupies TILE²+1 cycles after grant.
  - Earliest next grant is 1 cycle after DONE (IDLE evaluation cycle), so back-to-back tiles take TILE²+2 cycles each.
- Pixel order is row-major from (x0,y0), one pixel per cycle.
- Reset asserted mid-FILL
  - Immediately forces IDLE with all outputs zeroed.
  - The partial tile is not resumed and no `done` is issued.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration with pointer p, as in Operation.
- Undefined: fixed priority, lowest index wins; p and its update logic are not built.

## Test plan
- Single tile: req[0] with x=30, y=30, colour=3'b100 → 100 plot cycles covering x 30..39 and y 30..39, colour 100; done[0] pulses at cycle 101 after grant; busy low 1 cycle later.
- Contention: req = 3'b111 at the same edge, all held → grants in order 0, 1, 2 (both configurations). Then re-request all three:
  - round robin gives 0, 1, 2;
  - fixed priority gives 0 three times while req[0] is re-asserted after each done.
- Fairness, round robin: req[0] and req[1] re-asserted after every done → grants alternate 0, 1, 0, 1; no requester is granted twice in a row while the other waits.
- Clipping: x=155, y=115, TILE=10 → plot high only for x 155..159 and y 115..119 (25 pixels); FILL still lasts 100 cycles; done pulses normally.
- Mid-tile changes: change req_x[0] and drop req[0] at pixel 37 → remaining pixels use the latched origin; done[0] still pulses.
- Reset mid-FILL: Resetn low at pixel 50 → same cycle plot = 0 and grant = 0; after release, state is IDLE with p = 0 and no done pulse.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Shares one vga_adapter plot port among NREQ tile drawers; the owner's TILE x TILE square is walked row-major.
// Build with ARB_ROUND_ROBIN_EN defined for round-robin arbitration; otherwise fixed priority (lowest index wins).
module vga_plot_arbiter #(
   parameter int NREQ    = 3,
   parameter int TILE    = 10,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_x,
   input  logic [7*NREQ-1:0] req_y,
   input  logic [3*NREQ-1:0] req_colour,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [7:0]        VGA_X,
   output logic [6:0]        VGA_Y,
   output logic [2:0]        VGA_COLOR,
   output logic              plot
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [4:0] TLAST = 5'(TILE - 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state_q, state_d;
   logic [4:0]        xc_q, xc_d, yc_q, yc_d;
   logic [7:0]        x0_q, x0_d;
   logic [6:0]        y0_q, y0_d;
   logic [2:0]        col_q, col_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              win_vld;
   logic [GW-1:0]     win;
`ifdef ARB_ROUND_ROBIN_EN
   localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);
   logic [GW-1:0]     p_q, p_d, g_q, g_d;
`endif

   // Scan downwards so the last hit is the first requester in priority order.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(p_q) + k) % NREQ]) begin
            win_vld = 1'b1;
            win     = GW'((int'(p_q) + k) % NREQ);
         end
      end
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            win_vld = 1'b1;
            win     = GW'(k);
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      xc_d    = xc_q;
      yc_d    = yc_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      col_d   = col_q;
      grant_d = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
      p_d     = p_q;
      g_d     = g_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               x0_d    = req_x[8*int'(win) +: 8];
               y0_d    = req_y[7*int'(win) +: 7];
               col_d   = req_colour[3*int'(win) +: 3];
               xc_d    = '0;
               yc_d    = '0;
               grant_d = NREQ'(1) << win;
`ifdef ARB_ROUND_ROBIN_EN
               g_d     = win;
`endif
               state_d = FILL;
            end
         end
         FILL: begin
            if (xc_q == TLAST) begin
               xc_d = '0;
               if (yc_q == TLAST) begin
                  yc_d    = '0;
                  state_d = DONE;
               end else begin
                  yc_d = yc_q + 5'd1;
               end
            end else begin
               xc_d = xc_q + 5'd1;
            end
         end
         DONE: begin
            grant_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
            p_d     = (g_q == GLAST) ? '0 : g_q + GW'(1);
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         xc_q    <= '0;
         yc_q    <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         col_q   <= '0;
         grant_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         p_q     <= '0;
         g_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         xc_q    <= xc_d;
         yc_q    <= yc_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         col_q   <= col_d;
         grant_q <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
         p_q     <= p_d;
         g_q     <= g_d;
`endif
      end
   end

   // Clip test uses 9-bit sums so tiles hanging off the right/bottom edge do not wrap back on screen.
   logic [8:0] xs, ys;
   logic       fill;
   assign xs   = {1'b0, x0_q} + {4'b0, xc_q};
   assign ys   = {2'b0, y0_q} + {4'b0, yc_q};
   assign fill = (state_q == FILL);

   assign VGA_X     = fill ? xs[7:0] : '0;
   assign VGA_Y     = fill ? ys[6:0] : '0;
   assign VGA_COLOR = fill ? col_q : '0;
   assign plot      = fill && (xs < 9'(XSCREEN)) && (ys < 9'(YSCREEN));
   assign grant     = grant_q;
   assign done      = (state_q == DONE) ? grant_q : '0;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed and randomized checks of vga_plot_arbiter against a transaction-level reference model.
module tb_vga_plot_arbiter;
   localparam int NREQ = 3;
   localparam int TILE = 10;
   localparam int XS   = 160;
   localparam int YS   = 120;

   logic              CLOCK_50;
   logic              Resetn;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_x;
   logic [7*NREQ-1:0] req_y;
   logic [3*NREQ-1:0] req_colour;
   logic [NREQ-1:0]   grant, done;
   logic              busy, plot;
   logic [7:0]        VGA_X;
   logic [6:0]        VGA_Y;
   logic [2:0]        VGA_COLOR;

   vga_plot_arbiter #(.NREQ(NREQ), .TILE(TILE), .XSCREEN(XS), .YSCREEN(YS)) dut (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
      .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
      .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int tests = 0;
   int fails = 0;
   int rx[NREQ], ry[NREQ], rc[NREQ];
   int p_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_x[8*i +: 8]      = 8'(rx[i]);
         req_y[7*i +: 7]      = 7'(ry[i]);
         req_colour[3*i +: 3] = 3'(rc[i]);
      end
   endtask

   task automatic set_req(input int i, input int x, input int y, input int c);
      rx[i] = x; ry[i] = y; rc[i] = c;
      req[i] = 1'b1;
      drive();
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] rq);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NREQ; k++)
         if (rq[(p_m + k) % NREQ]) return (p_m + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++)
         if (rq[k]) return k;
`endif
      return -1;
   endfunction

   task automatic wait_grant(output int g);
      logic [NREQ-1:0] rq;
      g = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         rq = req;
         @(negedge CLOCK_50);
         if (grant != '0) begin
            g = model_winner(rq);
            chk("grant", 32'(grant), (g < 0) ? 32'd0 : (32'd1 << g));
            if (g < 0) g = -1;
            return;
         end
      end
      chk("grant_timeout", {31'b0, grant != '0}, 32'd1);
   endtask

   // One complete tile: pixels, done pulse, return to idle.
   task automatic serve(input int drop_at, input bit reassert, output int g, output int nplot);
      int x0, y0, c, ex, ey;
      nplot = 0;
      wait_grant(g);
      if (g < 0) return;
      x0 = rx[g]; y0 = ry[g]; c = rc[g];
      for (int n = 0; n < TILE*TILE; n++) begin
         if (n > 0) @(negedge CLOCK_50);
         if (n == drop_at) begin
            rx[g] = (rx[g] + 17) % 256;
            ry[g] = (ry[g] + 9) % 128;
            req[g] = 1'b0;
            drive();
         end
         ex = x0 + n % TILE;
         ey = y0 + n / TILE;
         chk("vga_x", 32'(VGA_X), ex % 256);
         chk("vga_y", 32'(VGA_Y), ey % 128);
         chk("vga_color", 32'(VGA_COLOR), c);
         chk("plot", 32'(plot), (ex < XS && ey < YS) ? 1 : 0);
         chk("busy_fill", 32'(busy), 1);
         chk("grant_fill", 32'(grant), 32'd1 << g);
         if (plot) nplot++;
      end
      @(negedge CLOCK_50);
      chk("done_pulse", 32'(done), 32'd1 << g);
      chk("plot_done", 32'(plot), 0);
      chk("busy_done", 32'(busy), 1);
      req[g] = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      p_m = (g + 1) % NREQ;
`endif
      @(negedge CLOCK_50);
      chk("busy_idle", 32'(busy), 0);
      chk("grant_idle", 32'(grant), 0);
      chk("done_idle", 32'(done), 0);
      if (reassert) req[g] = 1'b1;
   endtask

   task automatic drain();
      int g, np;
      for (int k = 0; k < 8 && req != '0; k++) serve(-1, 1'b0, g, np);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_plot"}, 32'(plot), 0);
      chk({tag, "_x"}, 32'(VGA_X), 0);
      chk({tag, "_y"}, 32'(VGA_Y), 0);
      chk({tag, "_col"}, 32'(VGA_COLOR), 0);
   endtask

   initial begin
      int g, np, prev;
      Resetn = 1'b0;
      req = '0;
      for (int i = 0; i < NREQ; i++) begin rx[i] = 0; ry[i] = 0; rc[i] = 0; end
      drive();
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk_zero_outputs("reset");
      Resetn = 1'b1;
      @(negedge CLOCK_50);

      // Single tile fully on screen
      set_req(0, 30, 30, 3'b100);
      serve(-1, 1'b0, g, np);
      chk("single_plotted", np, 100);

      // Contention, all held until their own done
      for (int i = 0; i < NREQ; i++)
         set_req(i, $urandom_range(150), $urandom_range(110), $urandom_range(7));
      for (int k = 0; k < NREQ; k++) serve(-1, 1'b0, g, np);
      chk("contention_drained", 32'(req), 0);

      // Re-request all, each re-asserting after its done
      for (int i = 0; i < NREQ; i++)
         set_req(i, $urandom_range(150), $urandom_range(110), $urandom_range(7));
      for (int k = 0; k < NREQ; k++) serve(-1, 1'b1, g, np);
      drain();

      // Fairness between two persistent requesters
      set_req(0, 10, 20, 1);
      set_req(1, 50, 60, 2);
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         serve(-1, 1'b1, g, np);
`ifdef ARB_ROUND_ROBIN_EN
         if (prev >= 0 && g >= 0) chk("rr_no_repeat", 32'(grant == '0 && g != prev), 1);
`endif
         prev = g;
      end
      drain();

      // Clipping at bottom-right corner
      set_req(1, 155, 115, 3'b011);
      serve(-1, 1'b0, g, np);
      chk("clip_plotted", np, 25);

      // Origin change and request drop mid-tile
      set_req(0, 70, 40, 3'b110);
      serve(37, 1'b0, g, np);
      chk("midchange_plotted", np, 100);

      // Randomized arrivals
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req[i] && $urandom_range(1) == 1)
               set_req(i, $urandom_range(255), $urandom_range(127), $urandom_range(7));
         if (req == '0) set_req(it % NREQ, $urandom_range(255), $urandom_range(127), $urandom_range(7));
         serve(-1, 1'b0, g, np);
      end
      drain();

      // Reset in the middle of a fill
      set_req(2, 20, 20, 3'b101);
      wait_grant(g);
      repeat (50) @(negedge CLOCK_50);
      Resetn = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      p_m = 0;
      req = '0;
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLOCK_50);
         chk("postreset_done", 32'(done), 0);
         chk("postreset_busy", 32'(busy), 0);
      end
      set_req(1, 5, 5, 3'b001);
      set_req(2, 90, 90, 3'b010);
      serve(-1, 1'b0, g, np);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
